fmul_sched: RTL and testbench
=============================

// Module: fmul_sched
// PURPOSE
//  Shares one fmul single-precision multiplier between NREQ requesters.
//  fmul is iterative, not pipelined, has no done flag, and reads x/y combinationally for the whole op.
//  This block arbitrates round-robin and holds the operands stable for fmul.
//  It times the fixed latency and returns the result with the requester tag on a valid/ready port.
//  Sits between issue logic (FPU lanes) and the single fmul instance.
// PARAMETERS
//  NREQ      4   number of requesters (2..8)
//  TAGW      2   tag width, >= clog2(NREQ)
//  FMUL_LAT  5   cycles after the fmul req cycle until fmul rslt is stable
// PORTS
//  clk         in   1          clock, rising edge
//  reset       in   1          asynchronous, active-high reset
//  req_valid   in   NREQ       per-requester operand valid
//  req_ready   out  NREQ       per-requester grant/accept (at most one bit set)
//  req_x       in   NREQ*32    operand x, requester k at [32k+31:32k]
//  req_y       in   NREQ*32    operand y, same packing
//  rsp_valid   out  1          result valid
//  rsp_ready   in   1          result consumer ready
//  rsp_tag     out  TAGW       index of requester that owns rsp_data
//  rsp_data    out  32         IEEE-754 single result
//  fmul_req    out  1          start pulse to fmul (registered)
//  fmul_x      out  32         held operand x to fmul
//  fmul_y      out  32         held operand y to fmul
//  fmul_rslt   in   32         fmul result
//  busy        out  1          state != IDLE
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; rr_ptr=0; fmul_req=0; rsp_valid=0.
//   Also on reset: rsp_tag=0, rsp_data=0, fmul_x=0, fmul_y=0, cnt=0.
//  FSM states: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//  IDLE:
//   - req_ready is one-hot: the first valid requester at or after rr_ptr (wrapping), else 0.
//   - req_ready is combinational from req_valid/rr_ptr and is zero in every other state.
//   - On handshake (req_valid[k] & req_ready[k]):
//     latch fmul_x=req_x[k], fmul_y=req_y[k], rsp_tag=k; rr_ptr=(k+1) mod NREQ; go ISSUE.
//  ISSUE:
//   - Lasts 1 cycle with fmul_req=1.
//   - cnt loaded with FMUL_LAT; go WAIT.
//  WAIT:
//   - fmul_req=0; cnt decrements each cycle.
//   - When cnt==0: capture rsp_data=fmul_rslt, set rsp_valid=1, go DONE.
//   - WAIT therefore lasts FMUL_LAT+1 cycles.
//  DONE:
//   - rsp_valid=1; rsp_data and rsp_tag are stable.
//   - On rsp_ready: rsp_valid=0, go IDLE. rsp_ready low stalls indefinitely.
//  Timing: handshake in cycle T -> fmul_req in T+1 -> rsp_valid from T+8 (FMUL_LAT=5).
//   Back-to-back throughput is one op per 9 cycles.
//  fmul_x/fmul_y change only at the IDLE handshake; they are held through ISSUE/WAIT/DONE.
//  Requester drops req_valid in IDLE: no grant, no state change.
//   A non-granted requester may change operands freely.
//  All-zero req_valid: stay IDLE; rr_ptr unchanged.
//  rr_ptr wraps from NREQ-1 to 0.
//  Reset mid-op (ISSUE/WAIT/DONE): the operation is discarded and no rsp is produced.
//   fmul has no usable reset; its next fmul_req reinitialises it, so no flush is needed.
//  rsp_ready with rsp_valid=0 is ignored.
// STRUCTURE
//  fmul_pkg: FMUL_LAT constant, state enum {IDLE,ISSUE,WAIT,DONE}, and the 32-bit float type.
//  Sub-module rr_arbiter (NREQ): takes req/ptr, gives one-hot grant and encoded index.
//   Purely combinational; rr_ptr stays in fmul_sched.
//  fmul is instantiated by the parent, not inside this block.
// TESTING
//  Bench instantiates fmul_sched + fmul; scoreboard checks rsp_tag/rsp_data against a float reference model.
//  1 single op: req0 x=0x3F800000 y=0x40000000
//    -> fmul_req at T+1; rsp_valid at T+8; tag=0; data=0x40000000.
//  2 sign: req2 x=0x40400000 (3.0) y=0xC0000000 (-2.0) -> tag=2, data=0xC0C00000.
//  3 fairness: all 4 valid continuously, ptr=0 -> grant order 0,1,2,3,0.
//    Each op gets correct tag/data; req_ready one-hot only in IDLE.
//  4 backpressure: rsp_ready=0 for 20 cycles after rsp_valid.
//    -> data/tag stable, no new grant, fmul_x stable; one cycle after release the block is IDLE.
//  5 reset mid-WAIT: assert reset at T+4.
//    -> rsp_valid=0, busy=0 immediately; next request returns correct result, rr_ptr restarted at 0.
//  6 operand change: requester 1 alters req_x while requester 0's op is in WAIT
//    -> requester 0's result unaffected; requester 1 gets its latest operands.

Source files
------------

// File: rtl/fmul_pkg.sv
// Shared constants and types for the fmul request scheduler.
package fmul_pkg;

   localparam int FMUL_LAT = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef logic [31:0] float32_t;

endpackage

// File: rtl/fmul_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDXW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDXW-1:0] idx,
   output logic            any
);

   logic [IDXW:0]   sum;
   logic [IDXW-1:0] pos;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      sum   = '0;
      pos   = '0;
      // Walk offsets from farthest to nearest so the nearest valid one wins.
      for (int i = NREQ - 1; i >= 0; i--) begin
         sum = {1'b0, ptr} + (IDXW + 1)'(i);
         if (sum >= (IDXW + 1)'(NREQ))
            sum = sum - (IDXW + 1)'(NREQ);
         pos = sum[IDXW-1:0];
         if (req[pos]) begin
            grant      = '0;
            grant[pos] = 1'b1;
            idx        = pos;
            any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fmul_sched.sv
// Round-robin front end for a single iterative fmul: holds operands,
// times the fixed latency and returns the tagged result on a valid/ready port.
module fmul_sched
   import fmul_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int TAGW     = 2,
   parameter int FMUL_LAT = fmul_pkg::FMUL_LAT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*32-1:0] req_x,
   input  logic [NREQ*32-1:0] req_y,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [TAGW-1:0]    rsp_tag,
   output float32_t           rsp_data,
   output logic               fmul_req,
   output float32_t           fmul_x,
   output float32_t           fmul_y,
   input  float32_t           fmul_rslt,
   output logic               busy
);

   localparam int IDXW = $clog2(NREQ);
   localparam int CNTW = $clog2(FMUL_LAT + 1);

   state_t            state, state_next;
   logic [IDXW-1:0]   rr_ptr;
   logic [CNTW-1:0]   cnt;
   logic [NREQ-1:0]   grant;
   logic [IDXW-1:0]   grant_idx;
   logic              grant_any;
   logic              handshake;

   rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_arb (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (grant_idx),
      .any   (grant_any)
   );

   always_comb begin
      state_next = state;
      req_ready  = '0;
      handshake  = 1'b0;
      case (state)
         IDLE: begin
            req_ready = grant;
            handshake = grant_any;
            if (grant_any)
               state_next = ISSUE;
         end
         ISSUE: state_next = WAIT;
         WAIT: begin
            if (cnt == '0)
               state_next = DONE;
         end
         DONE: begin
            if (rsp_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         fmul_req  <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_tag   <= '0;
         rsp_data  <= '0;
         fmul_x    <= '0;
         fmul_y    <= '0;
         cnt       <= '0;
      end else begin
         state    <= state_next;
         fmul_req <= handshake;
         // Operands are captured only here, so fmul sees them stable for the whole op.
         if (handshake) begin
            fmul_x  <= req_x[32*grant_idx +: 32];
            fmul_y  <= req_y[32*grant_idx +: 32];
            rsp_tag <= TAGW'(grant_idx);
            rr_ptr  <= (grant_idx == IDXW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
         end
         if (state == ISSUE)
            cnt <= CNTW'(FMUL_LAT);
         else if (state == WAIT && cnt != '0)
            cnt <= cnt - 1'b1;
         if (state == WAIT && cnt == '0) begin
            rsp_data  <= fmul_rslt;
            rsp_valid <= 1'b1;
         end
         if (state == DONE && rsp_ready)
            rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fmul_sched.sv
// Bench for fmul_sched: stand-in fmul, cycle-level reference model and directed ops.
module tb_fmul_sched;

   localparam int NREQ = 4;
   localparam int TAGW = 2;
   localparam int LAT  = 5;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic [NREQ-1:0]    req_valid = '0;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*32-1:0] req_x = '0;
   logic [NREQ*32-1:0] req_y = '0;
   logic               rsp_valid;
   logic               rsp_ready = 1'b1;
   logic [TAGW-1:0]    rsp_tag;
   logic [31:0]        rsp_data;
   logic               fmul_req;
   logic [31:0]        fmul_x;
   logic [31:0]        fmul_y;
   logic [31:0]        fmul_rslt;
   logic               busy;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fmul_sched #(.NREQ(NREQ), .TAGW(TAGW), .FMUL_LAT(LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_x     (req_x),
      .req_y     (req_y),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_tag   (rsp_tag),
      .rsp_data  (rsp_data),
      .fmul_req  (fmul_req),
      .fmul_x    (fmul_x),
      .fmul_y    (fmul_y),
      .fmul_rslt (fmul_rslt),
      .busy      (busy)
   );

   // Exact single-precision product for normal operands (truncating).
   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      logic [47:0] p;
      logic [22:0] m;
      int          e;
      logic        s;
      s = a[31] ^ b[31];
      if (a[30:0] == 31'd0 || b[30:0] == 31'd0)
         return {s, 31'd0};
      p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (p[47]) begin
         e = e + 1;
         m = p[46:24];
      end else begin
         m = p[45:23];
      end
      return {s, e[7:0], m};
   endfunction

   // Stand-in fmul: garbage until LAT cycles after the req cycle, then a live
   // combinational product of whatever fmul_x/fmul_y currently hold.
   int fcnt = 0;
   always @(posedge clk) begin
      if (fmul_req)
         fcnt <= LAT;
      else if (fcnt > 0)
         fcnt <= fcnt - 1;
   end
   assign fmul_rslt = (fcnt > 1) ? 32'hDEAD_BEEF : ref_mul(fmul_x, fmul_y);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      tests++;
      fails++;
      $display("[TB] FAIL %s: timed out at cycle %0d", name, cyc);
   endtask

   function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] v, input int ptr);
      for (int i = 0; i < NREQ; i++) begin
         if (v[(ptr + i) % NREQ])
            return NREQ'(1) << ((ptr + i) % NREQ);
      end
      return '0;
   endfunction

   function automatic int onehot_idx(input logic [NREQ-1:0] g);
      for (int i = 0; i < NREQ; i++)
         if (g[i]) return i;
      return -1;
   endfunction

   // Reference model: m_k = cycles since handshake (0 = idle, 8+ = result held).
   int          m_k = 0;
   int          m_ptr = 0;
   int          m_tag = 0;
   logic [31:0] m_x = '0;
   logic [31:0] m_y = '0;

   always @(negedge clk) begin
      logic [NREQ-1:0] exp_ready;
      int              k;
      if (reset) begin
         chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
         chk("rst_busy", {31'd0, busy}, 32'd0);
         chk("rst_fmul_req", {31'd0, fmul_req}, 32'd0);
         m_k   = 0;
         m_ptr = 0;
      end else begin
         exp_ready = (m_k == 0) ? rr_pick(req_valid, m_ptr) : '0;
         chk("req_ready", {28'd0, req_ready}, {28'd0, exp_ready});
         chk("busy", {31'd0, busy}, {31'd0, m_k != 0});
         chk("fmul_req", {31'd0, fmul_req}, {31'd0, m_k == 1});
         chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_k >= 8});
         if (m_k >= 1) begin
            chk("fmul_x", fmul_x, m_x);
            chk("fmul_y", fmul_y, m_y);
         end
         if (m_k >= 8) begin
            chk("rsp_tag", {30'd0, rsp_tag}, 32'(m_tag));
            chk("rsp_data", rsp_data, ref_mul(m_x, m_y));
         end
         if (m_k == 0 && exp_ready != '0) begin
            k     = onehot_idx(exp_ready);
            m_x   = req_x[32*k +: 32];
            m_y   = req_y[32*k +: 32];
            m_tag = k;
            m_ptr = (k + 1) % NREQ;
            m_k   = 1;
         end else if (m_k >= 1 && m_k < 8) begin
            m_k = m_k + 1;
         end else if (m_k >= 8 && rsp_ready) begin
            $display("[TB] rsp tag=%0d data=%h cycle=%0d", rsp_tag, rsp_data, cyc);
            m_k = 0;
         end
      end
   end

   task automatic wait_grant(output int idx, output int t);
      idx = -1;
      t   = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            idx = onehot_idx(req_ready);
            t   = cyc;
            return;
         end
      end
      timeout("wait_grant");
   endtask

   task automatic wait_rsp(output int t);
      t = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            t = cyc;
            return;
         end
      end
      timeout("wait_rsp");
   endtask

   task automatic set_ops(input int k, input logic [31:0] x, input logic [31:0] y);
      req_x[32*k +: 32] = x;
      req_y[32*k +: 32] = y;
   endtask

   task automatic do_op(input string name, input int k, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_data);
      int g, t0, t1;
      @(posedge clk); #1;
      set_ops(k, x, y);
      req_valid[k] = 1'b1;
      wait_grant(g, t0);
      chk({name, "_grant"}, 32'(g), 32'(k));
      @(posedge clk); #1;
      req_valid[k] = 1'b0;
      wait_rsp(t1);
      chk({name, "_latency"}, 32'(t1 - t0), 32'd8);
      chk({name, "_tag"}, {30'd0, rsp_tag}, 32'(k));
      chk({name, "_data"}, rsp_data, exp_data);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   initial begin
      int g, t0, t1;
      logic [31:0] fx [NREQ];
      logic [31:0] fp [NREQ];
      int order [5];
      fx = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
      fp = '{32'h4000_0000, 32'h4080_0000, 32'h40C0_0000, 32'h4100_0000};
      order = '{0, 1, 2, 3, 0};

      // Pin the reference multiplier to hand-computed products.
      chk("model_1x2", ref_mul(32'h3F80_0000, 32'h4000_0000), 32'h4000_0000);
      chk("model_3xm2", ref_mul(32'h4040_0000, 32'hC000_0000), 32'hC0C0_0000);
      chk("model_3x3", ref_mul(32'h4040_0000, 32'h4040_0000), 32'h4110_0000);

      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_rsp_data", rsp_data, 32'd0);
      chk("reset_fmul_x", fmul_x, 32'd0);

      do_op("single", 0, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000);
      do_op("sign", 2, 32'h4040_0000, 32'hC000_0000, 32'hC0C0_0000);

      // Fairness: all requesters valid from ptr=0.
      pulse_reset();
      for (int k = 0; k < NREQ; k++) set_ops(k, fx[k], 32'h4000_0000);
      req_valid = '1;
      for (int i = 0; i < 5; i++) begin
         wait_grant(g, t0);
         chk("fair_grant", 32'(g), 32'(order[i]));
         wait_rsp(t1);
         chk("fair_tag", {30'd0, rsp_tag}, 32'(order[i]));
         chk("fair_data", rsp_data, fp[order[i]]);
      end
      @(posedge clk); #1;
      req_valid = '0;

      // Backpressure for 20 cycles with another requester waiting.
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      set_ops(0, 32'h4040_0000, 32'h4040_0000);
      req_valid[0] = 1'b1;
      wait_grant(g, t0);
      chk("bp_grant", 32'(g), 32'd0);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      set_ops(2, 32'h4000_0000, 32'h4000_0000);
      req_valid[2] = 1'b1;
      wait_rsp(t1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp_data", rsp_data, 32'h4110_0000);
         chk("bp_tag", {30'd0, rsp_tag}, 32'd0);
         chk("bp_no_grant", {28'd0, req_ready}, 32'd0);
         chk("bp_fmul_x", fmul_x, 32'h4040_0000);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_idle_busy", {31'd0, busy}, 32'd0);
      chk("bp_idle_valid", {31'd0, rsp_valid}, 32'd0);
      wait_grant(g, t0);
      chk("bp_next_grant", 32'(g), 32'd2);
      @(posedge clk); #1;
      req_valid[2] = 1'b0;
      wait_rsp(t1);
      chk("bp_next_data", rsp_data, 32'h4080_0000);

      // Reset in the middle of WAIT discards the op.
      @(posedge clk); #1;
      set_ops(3, 32'h4040_0000, 32'h4000_0000);
      req_valid[3] = 1'b1;
      wait_grant(g, t0);
      chk("rst_mid_grant", 32'(g), 32'd3);
      @(posedge clk); #1;
      req_valid[3] = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      set_ops(0, 32'h4080_0000, 32'h3F80_0000);
      set_ops(1, 32'h4040_0000, 32'h4040_0000);
      req_valid = 4'b0011;
      wait_grant(g, t0);
      chk("rst_ptr_restart", 32'(g), 32'd0);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      wait_rsp(t1);
      chk("rst_after_data", rsp_data, 32'h4080_0000);
      chk("rst_after_tag", {30'd0, rsp_tag}, 32'd0);
      wait_grant(g, t0);
      chk("rst_after_grant1", 32'(g), 32'd1);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      wait_rsp(t1);
      chk("rst_after_data1", rsp_data, 32'h4110_0000);

      // Requester 1 churns its operands while requester 0's op is in flight.
      @(posedge clk); #1;
      set_ops(0, 32'h4080_0000, 32'h4000_0000);
      req_valid[0] = 1'b1;
      wait_grant(g, t0);
      chk("chg_grant0", 32'(g), 32'd0);
      @(posedge clk); #1;
      req_valid = 4'b0010;
      set_ops(1, 32'h3F80_0000, 32'h4000_0000);
      @(posedge clk); #1;
      set_ops(1, 32'h4000_0000, 32'h4000_0000);
      @(posedge clk); #1;
      set_ops(1, 32'h40A0_0000, 32'h4000_0000);
      wait_rsp(t1);
      chk("chg_data0", rsp_data, 32'h4100_0000);
      chk("chg_tag0", {30'd0, rsp_tag}, 32'd0);
      wait_grant(g, t0);
      chk("chg_grant1", 32'(g), 32'd1);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      wait_rsp(t1);
      chk("chg_data1", rsp_data, 32'h4120_0000);
      chk("chg_tag1", {30'd0, rsp_tag}, 32'd1);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
